// File: rtl/izh_synaptic_accum.sv
// Synaptic current accumulator for the Izhikevich neuron pipeline.
// Once per timestep it walks the weight RAM row by row and produces, for
// every postsynaptic neuron j, i[j] = bias + sum of W[j][k] over fired k.
// All arithmetic is 17-bit sign-magnitude Q8.8 with per-addition saturation.
module izh_synaptic_accum #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] spike_vec,
  input  logic [16:0]          bias,
  output logic                 w_rd_en,
  output logic [2*IDX_W-1:0]   w_addr,
  input  logic [16:0]          w_data,
  output logic [16:0]          i_out,
  output logic [IDX_W-1:0]     i_idx,
  output logic                 i_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t state, state_nxt;

  // Run context: post/pre counters, accumulator and the inputs frozen at start
  logic [IDX_W-1:0]     j, k;
  logic [16:0]          acc;
  logic [N_NEURONS-1:0] spike_lat;
  logic [16:0]          bias_lat;

  // Read pipeline tracking: which pre index the current w_data belongs to
  logic                 rd_q;
  logic [IDX_W-1:0]     k_q;

  // Next values for every register
  logic [IDX_W-1:0]     j_nxt, k_nxt;
  logic [16:0]          acc_nxt, bias_nxt, i_out_nxt;
  logic [N_NEURONS-1:0] spike_nxt;
  logic [IDX_W-1:0]     i_idx_nxt;
  logic                 i_valid_nxt, busy_nxt, done_nxt, rd_en_nxt;
  logic [2*IDX_W-1:0]   addr_nxt;

  logic                 add_en;
  logic [16:0]          acc_sum;

  // A zero magnitude is always +0, whatever the incoming sign bit says
  function automatic logic [16:0] sm_norm(input logic [16:0] v);
    sm_norm = (v[15:0] == 16'd0) ? 17'd0 : v;
  endfunction

  // Sign-magnitude add: saturate like signs, subtract unlike signs, never -0
  function automatic logic [16:0] sm_add(input logic [16:0] a, input logic [16:0] b);
    logic [16:0] sum;
    sum = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    if (a[16] == b[16]) begin
      if (sum[16])
        sm_add = {a[16], 16'hFFFF};
      else if (sum[15:0] == 16'd0)
        sm_add = 17'd0;
      else
        sm_add = {a[16], sum[15:0]};
    end else if (a[15:0] > b[15:0]) begin
      sm_add = {a[16], a[15:0] - b[15:0]};
    end else if (b[15:0] > a[15:0]) begin
      sm_add = {b[16], b[15:0] - a[15:0]};
    end else begin
      sm_add = 17'd0;
    end
  endfunction

  // w_data is only meaningful the cycle after a read strobe; gate by the spike bit
  assign add_en  = rd_q && spike_lat[k_q];
  assign acc_sum = sm_add(acc, sm_norm(w_data));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: READ for every pre index, one DRAIN, one EMIT per neuron
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (k == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = EMIT;
      EMIT:    state_nxt = (j == LAST_IDX) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; every output is taken from a register
  always_comb begin
    j_nxt       = j;
    k_nxt       = k;
    acc_nxt     = acc;
    spike_nxt   = spike_lat;
    bias_nxt    = bias_lat;
    i_out_nxt   = i_out;
    i_idx_nxt   = i_idx;
    i_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    busy_nxt    = busy;
    case (state)
      IDLE: begin
        if (start) begin
          j_nxt     = '0;
          k_nxt     = '0;
          acc_nxt   = sm_norm(bias);
          spike_nxt = spike_vec;
          bias_nxt  = sm_norm(bias);
          busy_nxt  = 1'b1;
        end
      end
      READ: begin
        k_nxt = k + IDX_W'(1);
        if (add_en) acc_nxt = acc_sum;
      end
      DRAIN: begin
        if (add_en) acc_nxt = acc_sum;
      end
      EMIT: begin
        i_valid_nxt = 1'b1;
        i_out_nxt   = acc;
        i_idx_nxt   = j;
        if (j == LAST_IDX) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end else begin
          j_nxt   = j + IDX_W'(1);
          k_nxt   = '0;
          acc_nxt = bias_lat;
        end
      end
      default: ;
    endcase
    rd_en_nxt = (state_nxt == READ);
    addr_nxt  = {j_nxt, k_nxt};
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      spike_lat <= '0;
      bias_lat  <= '0;
      rd_q      <= 1'b0;
      k_q       <= '0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      i_out     <= '0;
      i_idx     <= '0;
      i_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      j         <= j_nxt;
      k         <= k_nxt;
      acc       <= acc_nxt;
      spike_lat <= spike_nxt;
      bias_lat  <= bias_nxt;
      rd_q      <= w_rd_en;
      k_q       <= w_addr[IDX_W-1:0];
      w_rd_en   <= rd_en_nxt;
      w_addr    <= addr_nxt;
      i_out     <= i_out_nxt;
      i_idx     <= i_idx_nxt;
      i_valid   <= i_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: doc/izh_synaptic_accum.md
Name: izh_synaptic_accum

Overview:
- Upstream stage of the Izhikevich neuron update. Once per simulation timestep it converts the previous step's spike vector into an input current i for each neuron.
- For each neuron j, i[j] is computed as i[j] = bias + sum of W[j][k] over every presynaptic k whose spike bit is set.
- Weights come from an external synchronous weight RAM.
- Currents are emitted one neuron at a time with an index, for the neuron update stage to consume.

Parameters:
- N_NEURONS, 8, number of neurons; must be a power of two, ≥2.
- IDX_W, 3, log2(N_NEURONS); width of a neuron index.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a timestep; sampled only in IDLE.
- spike_vec  in  N_NEURONS  fired flags from the previous step; bit k = presynaptic neuron k.
- bias  in  17  external drive current, Q8.8 sign-magnitude.
- w_rd_en  out  1  weight RAM read strobe.
- w_addr  out  2*IDX_W  weight RAM address {post j, pre k}.
- w_data  in  17  weight W[j][k]; valid exactly 1 cycle after the w_rd_en edge.
- i_out  out  17  accumulated current for neuron i_idx.
- i_idx  out  IDX_W  index of the neuron whose current is on i_out.
- i_valid  out  1  one-cycle strobe; i_out/i_idx are valid.
- busy  out  1  high while a timestep is in progress.
- done  out  1  one-cycle pulse; coincides with the i_valid of neuron N_NEURONS-1.

Behaviour:
- Number format:
  - 17-bit sign-magnitude. Bit16 is the sign (1 = negative). Bits15:8 are the integer part, bits7:0 the fraction (Q8.8).
  - -0 on any input is treated as +0.
- Reset:
  - All outputs go to 0. State goes to IDLE.
  - Accumulator, counters and latched inputs are cleared.
  - A run interrupted by reset produces no further i_valid or done.
- States: IDLE, READ, DRAIN, EMIT. All outputs are registered.
- IDLE:
  - If start=1 at edge T: latch spike_vec and bias; set j=0, k=0, acc=bias_latched, busy=1; go to READ.
  - Later changes to spike_vec or bias do not affect the current run.
- READ (N_NEURONS cycles):
  - Every cycle: w_rd_en=1, w_addr={j,k}.
  - w_data for k-1 arrives and is added to acc if spike_lat[k-1]=1.
  - k increments each cycle. After k=N_NEURONS-1, go to DRAIN.
  - Reads are issued for every k regardless of the spike bit. The timing is fixed.
- DRAIN (1 cycle):
  - w_rd_en=0.
  - Add the weight for k=N_NEURONS-1 if spike_lat[N_NEURONS-1]=1.
  - Go to EMIT.
- EMIT (1 cycle):
  - i_valid=1, i_out=acc, i_idx=j.
  - If j=N_NEURONS-1: done=1, busy=0 at the next edge, go to IDLE.
  - Otherwise: j++, k=0, acc=bias_latched, go to READ.
- Timing: neuron j's i_valid is high in the cycle T+(j+1)*(N_NEURONS+2). Total run length is N_NEURONS*(N_NEURONS+2) cycles after T.
- Back-to-back runs: start may be accepted in the first cycle after done; no bubble is required.
- start while busy is ignored. It is neither queued nor allowed to restart the run.
- Addition rules (sign-magnitude):
  - Equal signs: add the magnitudes and keep the sign. The magnitude saturates at 16'hFFFF (±255.996).
  - Opposite signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - An equal-magnitude result is +0 (sign bit 0).
  - Saturation is applied per addition, so later additions of the opposite sign may pull the result back from the limit.
- Consumer obligation: i_out/i_idx hold their values until the next i_valid. The consumer must capture on i_valid; there is no back-pressure.

Test Plan:
- N=8; bias=17'h00A00 (+10.0); spike_vec=0; start at T → i_valid at T+10, T+20 … T+80 with i_idx=0..7, each i_out=17'h00A00; done only at T+80; busy low at T+81.
- spike_vec=8'b0000_0100; W[0][2]=17'h00500 (+5.0); W[j][2]=17'h10200 (-2.0) for j≠0; bias=+10.0 → i_out[0]=17'h00F00, i_out[1..7]=17'h00800; w_addr sweeps {j,0..7} each neuron.
- Saturation: spike_vec=8'hFF; all W=17'h0F000 (+240.0); bias=0 → every i_out=17'h0FFFF.
- Cancellation: bias=17'h00300; W[j][0]=17'h10300; spike_vec=8'h01 → every i_out=17'h00000, never 17'h10000.
- Reset mid-run: assert rst at T+25 (neuron 2 in READ) → outputs 0 immediately; no i_valid/done afterward; a fresh start runs the full sequence correctly from i_idx=0.
- start pulsed at T+5 and T+40 during a run, and spike_vec changed at T+3 → ignored; results match the spike_vec latched at T; the next start is accepted at T+81.
